// File: rtl/uart_pkg.sv
// uart_pkg: tx state encoding, sampling constants shared with the receiver, parity helper.
package uart_pkg;
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
   localparam int BIT_SAMPLING     = 15;
   localparam int HALFBIT_SAMPLING = 7;
   function automatic logic parity(input logic [31:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/uart_transmitter.sv
// uart_transmitter: x16-tick UART TX, LSB first, one-entry holding register; UART_TX_PARITY_EN adds an even parity bit.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int BYTE_WIDTH    = 8,
   parameter int TICKS_PER_BIT = 16
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  tick,
   input  logic                  tx_valid,
   input  logic [BYTE_WIDTH-1:0] data_in,
   output logic                  tx_ready,
   output logic                  tx,
   output logic                  tx_busy,
   output logic                  tx_done
);
   localparam int TW = $clog2(TICKS_PER_BIT);
   localparam int BW = $clog2(BYTE_WIDTH);
   localparam logic [TW-1:0] LAST_TICK = TW'(TICKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(BYTE_WIDTH - 1);

   tx_state_e             state_q, state_d;
   logic [BYTE_WIDTH-1:0] hold_q, hold_d, shift_q, shift_d;
   logic                  hold_full_q, hold_full_d, tx_q, tx_d, done_q, done_d;
   logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  bit_end, load;
`ifdef UART_TX_PARITY_EN
   logic                  par_q, par_d;
`endif

   assign tx       = tx_q;
   assign tx_ready = !hold_full_q;
   assign tx_busy  = state_q != IDLE;
   assign tx_done  = done_q;

   always_comb begin
      state_d     = state_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      shift_d     = shift_q;
      tick_cnt_d  = tick_cnt_q;
      bit_cnt_d   = bit_cnt_q;
      done_d      = 1'b0;
      load        = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d       = par_q;
`endif
      bit_end = tick && (tick_cnt_q == LAST_TICK) && (state_q != IDLE);
      if (tick && state_q != IDLE) tick_cnt_d = bit_end ? '0 : tick_cnt_q + 1'b1;
      case (state_q)
         IDLE:  load = hold_full_q;
         START: if (bit_end) state_d = DATA;
         DATA: if (bit_end) begin
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_TX_PARITY_EN
            if (bit_cnt_q == LAST_BIT) state_d = PARITY;
`else
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_d = STOP;
`endif
         STOP: if (bit_end) begin
            done_d  = 1'b1;
            load    = hold_full_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // a queued byte at stop end restarts in the same edge, so frames run back to back
      if (load) begin
         state_d     = START;
         shift_d     = hold_q;
         hold_full_d = 1'b0;
         tick_cnt_d  = '0;
         bit_cnt_d   = '0;
`ifdef UART_TX_PARITY_EN
         par_d       = parity(32'(hold_q));
`endif
      end
      if (tx_valid && tx_ready) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end
`ifdef UART_TX_PARITY_EN
      tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PARITY) ? par_d : 1'b1;
`else
      tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : 1'b1;
`endif
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         shift_q     <= '0;
         tick_cnt_q  <= '0;
         bit_cnt_q   <= '0;
         tx_q        <= 1'b1;
         done_q      <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         shift_q     <= shift_d;
         tick_cnt_q  <= tick_cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         tx_q        <= tx_d;
         done_q      <= done_d;
`ifdef UART_TX_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: frame-level model of the transmitter (tick index -> frame bit) checked every cycle, plus directed frame decodes.
module tb_uart_transmitter;
   localparam int BW = 8;
`ifdef UART_TX_PARITY_EN
   localparam int NB = BW + 3;
`else
   localparam int NB = BW + 2;
`endif
   localparam int FT = NB * 16;

   logic          clk = 1'b0, arst = 1'b0, tick = 1'b0, tx_valid = 1'b0;
   logic [BW-1:0] data_in = '0;
   logic          tx_ready, tx, tx_busy, tx_done;
   int            total = 0, bad = 0, cyc = 0, tick_mode = 0;
   bit            cmp_en = 1'b0;
   logic          m_active, m_full, m_done, m_acc;
   logic [BW-1:0] m_hold;
   logic [NB-1:0] m_frame;
   int            m_ticks;
   logic          log_tx[$], log_done[$];

   uart_transmitter #(.BYTE_WIDTH(BW), .TICKS_PER_BIT(16)) dut (
      .clk(clk), .arst(arst), .tick(tick), .tx_valid(tx_valid), .data_in(data_in),
      .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", n, a, e);
      end
   endtask

   function automatic logic [NB-1:0] frame_of(input logic [BW-1:0] b);
`ifdef UART_TX_PARITY_EN
      return {1'b1, ^b, b, 1'b0};
`else
      return {1'b1, b, 1'b0};
`endif
   endfunction

   function automatic logic exp_tx();
      logic [NB-1:0] f;
      f = m_frame >> (m_ticks / 16);
      return m_active ? f[0] : 1'b1;
   endfunction

   task automatic model_reset();
      m_active = 1'b0; m_full = 1'b0; m_done = 1'b0; m_acc = 1'b0;
      m_hold = '0; m_frame = '1; m_ticks = 0;
   endtask

   task automatic model_update();
      logic was_idle;
      was_idle = !m_active;
      m_acc    = tx_valid && !m_full;
      m_done   = 1'b0;
      if (m_active && tick) begin
         m_ticks++;
         if (m_ticks == FT) begin
            m_done   = 1'b1;
            m_active = 1'b0;
         end
      end
      if ((was_idle || m_done) && m_full) begin
         m_frame  = frame_of(m_hold);
         m_ticks  = 0;
         m_active = 1'b1;
         m_full   = 1'b0;
      end
      if (m_acc) begin
         m_hold = data_in;
         m_full = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en && !arst) begin
         chk("tx", 32'(tx), 32'(exp_tx()));
         chk("busy", 32'(tx_busy), 32'(m_active));
         chk("ready", 32'(tx_ready), 32'(!m_full));
         chk("done", 32'(tx_done), 32'(m_done));
      end
   end

   task automatic step();
      @(posedge clk);
      model_update();
      cyc++;
      #1;
      log_tx.push_back(tx);
      log_done.push_back(tx_done);
      @(negedge clk);
      tick = (tick_mode == 0) ? ((cyc % 4) == 0) : (tick_mode == 1) ? ($urandom_range(0, 1) == 1) : 1'b0;
   endtask

   task automatic run(input int n);
      repeat (n) step();
   endtask

   task automatic clear_log();
      log_tx.delete();
      log_done.delete();
   endtask

   task automatic send(input logic [BW-1:0] b);
      int n;
      n = 0;
      tx_valid = 1'b1;
      data_in  = b;
      do begin
         step();
         n++;
      end while (!m_acc && n < 3000);
      if (!m_acc) chk("accept_timeout", 32'd0, 32'd1);
      tx_valid = 1'b0;
   endtask

   function automatic logic lt(input int i);
      return (i >= 0 && i < log_tx.size()) ? log_tx[i] : 1'bx;
   endfunction

   function automatic int first_low(input int from);
      for (int i = from; i < log_tx.size(); i++) if (log_tx[i] === 1'b0) return i;
      return -1;
   endfunction

   function automatic int first_done(input int from);
      for (int i = from; i < log_done.size(); i++) if (log_done[i] === 1'b1) return i;
      return -100000;
   endfunction

   function automatic int count_done();
      int c;
      c = 0;
      foreach (log_done[i]) if (log_done[i] === 1'b1) c++;
      return c;
   endfunction

   // decode one frame from the logged line assuming a tick every 4 clks (bit = 64 clks), sampling mid-bit
   task automatic check_frame(input string n, input int s, input logic [BW-1:0] b,
                              output int d, output logic [NB-1:0] bits);
      bits = '0;
      for (int k = 0; k < NB; k++) bits = {lt(s + 32 + 64 * k), bits[NB-1:1]};
      chk({n, "_frame"}, 32'(bits), 32'(frame_of(b)));
      d = first_done(s + 1);
      chk({n, "_len"}, 32'((d - s >= FT * 4 - 3) && (d - s <= FT * 4)), 32'd1);
   endtask

   task automatic async_reset();
      #2 arst = 1'b1;
      #1;
      chk("rst_tx", 32'(tx), 32'd1);
      chk("rst_busy", 32'(tx_busy), 32'd0);
      chk("rst_ready", 32'(tx_ready), 32'd1);
      chk("rst_done", 32'(tx_done), 32'd0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      arst = 1'b0;
   endtask

   initial begin
      int s, d, ai, changes;
      logic v;
      logic [NB-1:0] bits;
      logic [BW-1:0] lb[3];
      model_reset();
      #1 arst = 1'b1;
      #1;
      chk("init_tx", 32'(tx), 32'd1);
      chk("init_busy", 32'(tx_busy), 32'd0);
      chk("init_ready", 32'(tx_ready), 32'd1);
      chk("init_done", 32'(tx_done), 32'd0);
      repeat (2) @(negedge clk);
      arst   = 1'b0;
      cmp_en = 1'b1;

      clear_log();
      send(8'hA5);
      ai = log_tx.size() - 1;
      run(700);
      s = first_low(0);
      chk("a5_latency", 32'(s - ai), 32'd1);
      check_frame("a5", s, 8'hA5, d, bits);
      chk("a5_lit", 32'(bits[8:0]), 32'h14A);
      chk("a5_stop", 32'(bits[NB-1]), 32'd1);
      chk("a5_dones", 32'(count_done()), 32'd1);

      clear_log();
      send(8'h81);
      send(8'h3C);
      chk("b2b_ready_low", 32'(tx_ready), 32'd0);
      run(1500);
      s = first_low(0);
      check_frame("f81", s, 8'h81, d, bits);
      chk("b2b_gap", 32'(lt(d)), 32'd0);
      check_frame("f3c", d, 8'h3C, d, bits);
      chk("b2b_dones", 32'(count_done()), 32'd2);

      clear_log();
      send(8'h5A);
      run(200);
      tick_mode = 2;
      tick      = 1'b0;
      v         = tx;
      changes   = 0;
      repeat (100) begin
         step();
         if (tx !== v) changes++;
      end
      chk("stall_hold", 32'(changes), 32'd0);
      chk("stall_busy", 32'(tx_busy), 32'd1);
      tick_mode = 0;
      run(600);
      chk("stall_dones", 32'(count_done()), 32'd1);

      lb = '{8'h00, 8'hFF, 8'h55};
      foreach (lb[i]) begin
         clear_log();
         send(lb[i]);
         run(FT * 4 + 60);
         s = first_low(0);
         check_frame("loop", s, lb[i], d, bits);
      end

`ifdef UART_TX_PARITY_EN
      clear_log();
      send(8'h07);
      run(FT * 4 + 60);
      check_frame("par07", first_low(0), 8'h07, d, bits);
      chk("par07_bit", 32'(bits[9]), 32'd1);
      clear_log();
      send(8'h03);
      run(FT * 4 + 60);
      check_frame("par03", first_low(0), 8'h03, d, bits);
      chk("par03_bit", 32'(bits[9]), 32'd0);
`endif

      clear_log();
      send(8'hC3);
      run(150);
      send(8'h96);
      chk("pre_rst_busy", 32'(tx_busy), 32'd1);
      async_reset();
      run(20);

      tick_mode = 1;
      for (int i = 0; i < 16000; i++) begin
         if (!tx_valid || m_acc) begin
            tx_valid = ($urandom_range(0, 3) == 0);
            data_in  = 8'($urandom);
         end
         if (i == 8000) async_reset();
         step();
         if (log_tx.size() > 4000) clear_log();
      end
      tx_valid = 1'b0;
      run(10);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
UART serial transmitter, the transmit-side counterpart of the team's x16-oversampled UART receiver. It takes parallel bytes through a valid/ready handshake and serialises them LSB first: 1 start bit, BYTE_WIDTH data bits, 1 stop bit. Bit timing uses the shared baud x16 tick, so each bit lasts 16 ticks. A one-entry holding register lets the next byte be queued while the current frame shifts out, which allows back-to-back frames with no idle gap.

Parameters:
BYTE_WIDTH, 8, number of data bits per frame
TICKS_PER_BIT, 16, tick pulses per bit period; must match the receiver oversampling

Ports:
clk  input  1  system clock
arst  input  1  reset; one clock; reset is asynchronous and active-high
tick  input  1  baud x16 enable pulse, one clk wide
tx_valid  input  1  byte offered on data_in
data_in  input  BYTE_WIDTH  parallel byte to send
tx_ready  output  1  holding register empty; a byte is accepted when tx_valid && tx_ready
tx  output  1  serial line; idles high
tx_busy  output  1  high while a frame is on the line (any state except IDLE)
tx_done  output  1  one-clk pulse when a stop bit completes

Behaviour:
- Reset (arst=1, asynchronous): state=IDLE; tx=1; tx_ready=1; tx_busy=0; tx_done=0; holding register empty; tick counter=0; bit counter=0; shift register=0.
- Accept: on a clk edge with tx_valid && tx_ready, data_in is latched into the holding register and tx_ready drops the next cycle. tx_valid while tx_ready=0 is ignored; the source must hold it.
- FSM states: IDLE, START, DATA, PARITY (only with the optional feature), STOP. Encoding comes from the package enum.
- IDLE: tx=1. If the holding register is full, the next edge moves the byte into the shift register, empties the holding register (tx_ready=1), clears both counters and enters START. A byte accepted in cycle N therefore gives tx=0 from cycle N+2.
- Ticks are counted only in START, DATA, PARITY and STOP. On a tick with count==TICKS_PER_BIT-1, the count wraps to 0 and the bit advances; on any other tick the count increments. Without a tick, nothing changes.
- START: tx=0 for 16 ticks, then go to DATA with bit count 0.
- DATA: tx=shift[0]. At each bit end, shift right by 1. After bit BYTE_WIDTH-1 ends, go to STOP (or to PARITY when enabled).
- STOP: tx=1 for 16 ticks. At the end, pulse tx_done for 1 clk.
  - If the holding register is full at that moment, load it and go directly to START in the same edge, with no idle cycle.
  - Otherwise go to IDLE.
- Simultaneous accept and load: a byte may be accepted in the same cycle the holding register is drained; the new byte stays queued.
- tx is a registered output: it is driven from a flop and carries no combinational glitches.
- Reset mid-frame: tx returns high immediately; the partial frame and any queued byte are discarded.
- Frame length is exactly (BYTE_WIDTH+2)*16 ticks, or (BYTE_WIDTH+3)*16 ticks with parity.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state follows DATA. tx = XOR of all data bits (even parity) for 16 ticks, then STOP.
- Undefined: no PARITY state and no parity logic; DATA goes straight to STOP.
- The receiver must be built with the matching setting.

Decomposition:
- Shared package uart_pkg holds:
  - the tx state enum (logic [2:0]: IDLE, START, DATA, PARITY, STOP)
  - localparams BIT_SAMPLING=15 and HALFBIT_SAMPLING=7, shared with the receiver
  - a parity function
- No sub-module is needed. The single FSM plus datapath lands in about 150-200 lines. The baud tick generator is a separate existing block and stays outside.

Test Plan:
- Reset with arst=1 mid-frame -> tx=1, tx_busy=0 and tx_ready=1 asynchronously, before the next clk edge.
- Single byte: tick every 4 clks, send 0xA5 -> tx bits 0,1,0,1,0,0,1,0,1,1, each 64 clks long; tx_done pulses once after 640 clks; data matches.
- Back-to-back: queue 0x3C during the frame of 0x81 -> tx_ready=0 until 0x81 starts; 0x3C's start bit follows the stop bit with zero idle clks; 2 tx_done pulses.
- Tick stall: hold tick=0 for 100 clks mid-DATA -> tx holds its bit value and counters freeze.
- Loopback: wire tx to the receiver rx and send 0x00, 0xFF, 0x55 -> receiver rx_done fires with data_out equal to each byte.
- UART_TX_PARITY_EN defined, send 0x07 -> parity bit=1 between bit 7 and stop; 0x03 -> parity bit=0.
